// File: rtl/rr_arb_index_if.sv
// Arbiter bus: request/release from the requesters, registered grant index/valid/timeout back.
// The release strobe is named rel because "release" is a reserved word.
interface rr_arb_index_if #(
  parameter int unsigned n = 2
);
  logic [2**n-1:0] req;
  logic            rel;
  logic [n-1:0]    idx;
  logic            valid;
  logic            timeout;

  modport master (output req, output rel, input idx, input valid, input timeout);
  modport slave  (input req, input rel, output idx, output valid, output timeout);
endinterface

// File: rtl/rr_arb_index.sv
// Round-robin arbiter over 2**n requesters with a binary grant index, optional hold
// timeout, and one forced idle cycle between grants for break-before-make decoding.
module rr_arb_index #(
  parameter int unsigned n        = 2,
  parameter int unsigned HOLD_MAX = 0,
  parameter int unsigned CW       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  rr_arb_index_if.slave      bus
);
  localparam int unsigned    N         = 2**n;
  localparam logic [CW-1:0]  HOLD_LAST = CW'(HOLD_MAX - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state, state_n;
  logic [n-1:0]   idx, idx_n;
  logic           valid, valid_n;
  logic           timeout, timeout_n;
  logic [n-1:0]   ptr, ptr_n;
  logic [CW-1:0]  cnt, cnt_n;

  logic [n-1:0]   win, j;
  logic           found;
  logic           end_hold, end_time;

  // Rotating priority: first set request at or after ptr, wrapping mod N.
  always_comb begin
    win   = '0;
    found = 1'b0;
    j     = '0;
    for (int unsigned off = 0; off < N; off++) begin
      j = ptr + n'(off);
      if (!found && bus.req[j]) begin
        win   = j;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    valid_n   = valid;
    timeout_n = 1'b0;
    ptr_n     = ptr;
    cnt_n     = cnt;
    end_hold  = bus.rel || !bus.req[idx];
    end_time  = (HOLD_MAX != 0) && (cnt == HOLD_LAST);
    case (state)
      IDLE: begin
        valid_n = 1'b0;
        if (found) begin
          idx_n   = win;
          valid_n = 1'b1;
          cnt_n   = '0;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (end_hold || end_time) begin
          valid_n   = 1'b0;
          ptr_n     = idx + n'(1);
          timeout_n = end_time && !end_hold;
          state_n   = IDLE;
        end else if (cnt != '1) begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      valid   <= valid_n;
      timeout <= timeout_n;
      ptr     <= ptr_n;
      cnt     <= cnt_n;
    end
  end

  assign bus.idx     = idx;
  assign bus.valid   = valid;
  assign bus.timeout = timeout;
endmodule

// File: tb/tb_rr_arb_index.sv
// Directed-vector bench: stimulus pushes expected grants, a negedge monitor pops and checks them.
module tb_rr_arb_index;
  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  logic mon_en = 1'b0;

  typedef struct {
    logic [1:0] idx;
    int         len;   // expected valid-high cycles, 0 = not checked
    logic       to;    // expected timeout at the falling edge of valid
  } exp_t;
  exp_t q[$];

  rr_arb_index_if #(.n(2)) bus ();

  rr_arb_index #(.n(2), .HOLD_MAX(4), .CW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    vectors++;
    if (act !== req_v) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req_v, $time);
    end
  endtask

  task automatic expect_grant(input logic [1:0] i, input int len, input logic to);
    exp_t e;
    e.idx = i; e.len = len; e.to = to;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.valid) seen = 1'b1;
      else tick();
    end
    if (!seen) chk("grant_wait_timeout", 32'd0, 32'd1);
  endtask

  task automatic serve(input logic [3:0] nreq);
    wait_valid();
    bus.rel = 1'b1;
    tick();
    bus.rel = 1'b0;
    bus.req = nreq;
  endtask

  // Monitor: compares each grant against the queue head when valid rises,
  // then checks idx stability, hold length and the timeout flag at the fall.
  logic       prev_v = 1'b0;
  int         hi_cnt = 0;
  exp_t       cur;
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.valid && !prev_v) begin
        if (q.size() == 0) begin
          chk("unexpected_grant", 32'(bus.idx), 32'd99);
          cur.idx = bus.idx; cur.len = 0; cur.to = 1'b0;
        end else begin
          cur = q.pop_front();
          chk("grant_idx", 32'(bus.idx), 32'(cur.idx));
        end
        hi_cnt = 1;
      end else if (bus.valid && prev_v) begin
        hi_cnt++;
        chk("idx_stable", 32'(bus.idx), 32'(cur.idx));
      end else if (!bus.valid && prev_v) begin
        if (cur.len != 0) chk("hold_len", 32'(hi_cnt), 32'(cur.len));
        chk("timeout_at_end", 32'(bus.timeout), 32'(cur.to));
      end else begin
        chk("timeout_idle", 32'(bus.timeout), 32'd0);
      end
      prev_v = bus.valid;
    end
  end

  initial begin
    rst_n   = 1'b0;
    bus.req = 4'b1111;
    bus.rel = 1'b0;

    // Reset with all requests pending
    tick();
    tick();
    mon_en = 1'b1;
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_idx", 32'(bus.idx), 32'd0);
    chk("rst_timeout", 32'(bus.timeout), 32'd0);

    // Round robin with wrap; first grant one cycle after reset release
    expect_grant(2'd0, 1, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("first_grant_latency", 32'(bus.valid), 32'd1);
    serve(4'b1111);
    expect_grant(2'd1, 1, 1'b0); serve(4'b1111);
    expect_grant(2'd2, 1, 1'b0); serve(4'b1111);
    expect_grant(2'd3, 1, 1'b0); serve(4'b1111);
    expect_grant(2'd0, 1, 1'b0); serve(4'b1111);
    expect_grant(2'd1, 1, 1'b0); serve(4'b1111);
    expect_grant(2'd2, 1, 1'b0); serve(4'b0101);

    // Skip and wrap from ptr=3 with req=0101
    expect_grant(2'd0, 1, 1'b0); serve(4'b0101);
    expect_grant(2'd2, 1, 1'b0); serve(4'b0010);

    // Requester drops its request mid-grant
    expect_grant(2'd1, 1, 1'b0);
    wait_valid();
    bus.req = 4'b0000;
    tick();
    chk("drop_valid", 32'(bus.valid), 32'd0);
    bus.req = 4'b1011;
    expect_grant(2'd3, 1, 1'b0); serve(4'b0010);

    // Hold timeout after 4 cycles, regrant after one idle cycle
    expect_grant(2'd1, 4, 1'b1);
    wait_valid();
    tick(); tick(); tick(); tick();
    chk("timeout_valid_low", 32'(bus.valid), 32'd0);
    chk("timeout_pulse", 32'(bus.timeout), 32'd1);
    expect_grant(2'd1, 1, 1'b0);
    tick();
    chk("regrant_after_idle", 32'(bus.valid), 32'd1);
    chk("timeout_single_cycle", 32'(bus.timeout), 32'd0);
    bus.rel = 1'b1;
    tick();
    bus.rel = 1'b0;
    bus.req = 4'b0100;

    // Reset while idx=2 is granted
    expect_grant(2'd2, 2, 1'b0);
    wait_valid();
    tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_valid", 32'(bus.valid), 32'd0);
    chk("midrst_idx", 32'(bus.idx), 32'd0);
    bus.req = 4'b1111;
    rst_n   = 1'b1;
    expect_grant(2'd0, 1, 1'b0);
    tick();
    chk("midrst_regrant", 32'(bus.valid), 32'd1);
    bus.rel = 1'b1;
    tick();
    bus.rel = 1'b0;
    bus.req = 4'b0000;
    repeat (4) tick();
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
